// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage with registered valid/ready, flush and a
// saturating back-pressure counter.
module pipe_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state;
    state_e            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_ready_d;
    logic              out_valid_d;
    logic [1:0]        occupancy_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              accept;
    logic              emit;

    // Handshakes are built only from registered outputs, so in_ready never
    // depends combinationally on in_valid or out_ready.
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;
    assign out_data = main_q;

    // State and output registers; Reset overrides flush and all handshakes.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
            stall_cnt <= '0;
        end else begin
            state     <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            occupancy <= occupancy_d;
            stall_cnt <= stall_cnt_d;
        end
    end

    // Next state and datapath; an input offered during flush is dropped.
    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (emit) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs, decoded from the next state.
    always_comb begin
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
        occupancy_d = 2'(state_d);
        stall_cnt_d = stall_cnt;
        if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt_d = stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_skid_stage;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              Reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the stage is a FIFO of at most two entries.
    logic [DATA_W-1:0] m_q[$];
    int unsigned       m_cnt = 0;

    pipe_skid_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit em, ac, st;
        if (Reset) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            em = (m_q.size() > 0) && out_ready;
            ac = in_valid && (m_q.size() < 2);
            st = (m_q.size() > 0) && !out_ready;
            if (st && m_cnt < CNT_SAT) m_cnt++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (em) void'(m_q.pop_front());
                if (ac) m_q.push_back(in_data);
            end
        end
    endtask

    task automatic compare_all();
        int exp_data;
        exp_data = (m_q.size() > 0) ? int'(m_q[0]) : 0;
        chk("m_out_valid", int'(out_valid), int'(m_q.size() > 0));
        chk("m_in_ready",  int'(in_ready),  int'(m_q.size() < 2));
        chk("m_occupancy", int'(occupancy), m_q.size());
        chk("m_out_data",  int'(out_data),  exp_data);
        chk("m_stall_cnt", int'(stall_cnt), int'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at negedge.
    task automatic tick(input logic rst, input logic f, input logic v,
                        input logic [DATA_W-1:0] d, input logic r);
        Reset     = rst;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        // Reset, with in_valid asserted to show it is ignored
        tick(1'b1, 1'b0, 1'b1, 16'h0055, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 16'h0066, 1'b1);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_data",  int'(out_data),  0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);

        // Streaming: data appears one cycle after accept, occupancy stays 1
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, 1'b1, DATA_W'(k), 1'b1);
            chk("stream_data", int'(out_data),  k);
            chk("stream_occ",  int'(occupancy), 1);
        end
        chk("stream_stall", int'(stall_cnt), 0);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("drain_occ", int'(occupancy), 0);

        // Back-pressure: A, B fill the stage, C is held off
        tick(1'b0, 1'b0, 1'b1, 16'h000A, 1'b0);
        chk("bp_a_data", int'(out_data), 16'h000A);
        tick(1'b0, 1'b0, 1'b1, 16'h000B, 1'b0);
        chk("bp_two_occ",   int'(occupancy), 2);
        chk("bp_two_ready", int'(in_ready),  0);
        tick(1'b0, 1'b0, 1'b1, 16'h000C, 1'b0);
        chk("bp_hold_data", int'(out_data),  16'h000A);
        chk("bp_stall",     int'(stall_cnt), 2);
        tick(1'b0, 1'b0, 1'b1, 16'h000C, 1'b1);
        chk("bp_b_data", int'(out_data), 16'h000B);
        tick(1'b0, 1'b0, 1'b1, 16'h000C, 1'b1);
        chk("bp_c_data", int'(out_data), 16'h000C);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("bp_empty", int'(occupancy), 0);

        // Flush in TWO with 0xD offered: D is dropped
        tick(1'b0, 1'b0, 1'b1, 16'h0011, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 16'h0012, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 16'h000D, 1'b0);
        chk("fl_occ",       int'(occupancy), 0);
        chk("fl_out_valid", int'(out_valid), 0);
        chk("fl_out_data",  int'(out_data),  0);
        chk("fl_in_ready",  int'(in_ready),  1);
        chk("fl_stall",     int'(stall_cnt), 4);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fl_no_d", int'(out_valid), 0);

        // Saturation of the stall counter, then a flush leaves it saturated
        tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 16'h0005, 1'b0);
        chk("sat_start", int'(stall_cnt), 0);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            chk("sat_count", int'(stall_cnt), (i < 7) ? i : 7);
        end
        tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("sat_after_flush", int'(stall_cnt), 7);
        tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("sat_hold", int'(stall_cnt), 7);

        // Reset in TWO together with flush and out_ready
        tick(1'b0, 1'b0, 1'b1, 16'h0021, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 16'h0022, 1'b0);
        chk("rt_two", int'(occupancy), 2);
        tick(1'b1, 1'b1, 1'b1, 16'h0023, 1'b1);
        chk("rt_occ",       int'(occupancy), 0);
        chk("rt_out_valid", int'(out_valid), 0);
        chk("rt_out_data",  int'(out_data),  0);
        chk("rt_in_ready",  int'(in_ready),  1);
        chk("rt_stall",     int'(stall_cnt), 0);

        // Random traffic against the reference model
        for (int n = 0; n < 10000; n++) begin
            tick(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)),
                 DATA_W'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (in_ready && occupancy == 2'd2) begin
                chk("rand_ready_in_two", int'(in_ready), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32: payload width in bits (legal 1..256).
REQ-002 The block SHALL have parameter CNT_W, default 8: stall-counter width in bits (legal 1..32).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous pipeline squash.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: stage can accept; driven directly from a register.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: payload to the next stage.
REQ-012 The block SHALL have port occupancy, output, 2 bits: number of held entries (0..2).
REQ-013 The block SHALL have port stall_cnt, output, CNT_W bits: count of back-pressured cycles.

Function
REQ-014 The block SHALL hold two DATA_W registers, main and skid; out_data SHALL always equal main.
REQ-015 Accept SHALL occur when in_valid=1 and in_ready=1; emit SHALL occur when out_valid=1 and out_ready=1.
REQ-016 The block SHALL implement states EMPTY (occupancy 0), ONE (occupancy 1) and TWO (occupancy 2), with out_valid=1 in ONE and TWO and in_ready=1 in EMPTY and ONE.
REQ-017 In EMPTY, accept SHALL load main with in_data and go to ONE; with no accept the state SHALL remain EMPTY.
REQ-018 In ONE, accept with emit SHALL load main with in_data and stay in ONE, giving full throughput.
REQ-019 In ONE, accept without emit SHALL load skid with in_data, leave main unchanged and go to TWO.
REQ-020 In ONE, emit without accept SHALL clear main to 0 and go to EMPTY.
REQ-021 In TWO, emit SHALL copy skid to main, clear skid to 0 and go to ONE; with no emit the state SHALL hold.
REQ-022 In TWO, in_valid SHALL be ignored, because in_ready=0.
REQ-023 Data SHALL leave the block in acceptance order: no loss, no duplication, no reordering.
REQ-024 Latency from accept to out_valid SHALL be exactly 1 cycle when the stage is EMPTY.
REQ-025 When out_valid=1 and out_ready=0, out_data SHALL stay stable until emit.
REQ-026 flush=1 SHALL, on the next edge, force state EMPTY, clear main and skid to 0 and set in_ready=1.
REQ-027 An input presented with flush=1 SHALL be dropped, not stored.
REQ-028 An emit that coincides with flush SHALL still count as a transfer downstream.
REQ-029 stall_cnt SHALL increment by 1 on every cycle with out_valid=1 and out_ready=0.
REQ-030 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-031 stall_cnt SHALL be unaffected by flush.
REQ-032 All outputs SHALL be registered or driven by a direct decode of registered state; there SHALL be no combinational path from out_ready or in_valid to in_ready.

Reset
REQ-033 Reset=1 at a rising edge SHALL set state EMPTY, main=0, skid=0, out_valid=0, in_ready=1, occupancy=0 and stall_cnt=0.
REQ-034 Reset SHALL take priority over flush and over every handshake in the same cycle.
REQ-035 Asserting Reset mid-operation SHALL discard both held entries with no further emit.
REQ-036 While Reset is held high, in_valid SHALL be ignored.

Verification
REQ-037 Streaming: out_ready=1, in_valid=1, in_data = 1,2,3,... -> out_data follows one cycle later, occupancy stays 1, stall_cnt stays 0.
REQ-038 Back-pressure: accept 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready=0; 0xC is held off; on out_ready=1 the outputs are 0xA, 0xB, 0xC in order.
REQ-039 Flush in TWO with in_valid=1 (0xD) -> next cycle occupancy 0, out_valid 0, out_data 0, in_ready 1; 0xD never appears at the output.
REQ-040 Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reads 1..7 and then stays at 7; a later flush leaves it at 7.
REQ-041 Reset in TWO asserted together with flush and out_ready=1 -> all outputs at reset values and no emit is counted as valid.
REQ-042 Random: random in_valid, out_ready and flush over 10k cycles, checked against a scoreboard -> ordering holds, no loss except flushed entries, in_ready never 1 in TWO.
